// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode constants, widths, payload struct and opcode latency lookup
// for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned LAT_FAST = 1;
  localparam int unsigned LAT_SLOW = 2;
  localparam int unsigned CNT_W    = 2;

  localparam logic [SEL_W-1:0] OP_FWD  = 3'b000;
  localparam logic [SEL_W-1:0] OP_ADD  = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND  = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR   = 3'b011;
  localparam logic [SEL_W-1:0] OP_MULT = 3'b100;
  localparam logic [SEL_W-1:0] OP_SL   = 3'b101;
  localparam logic [SEL_W-1:0] OP_SA   = 3'b110;
  localparam logic [SEL_W-1:0] OP_RO   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } alu_req_t;

  // Forward/and/or settle in one cycle; everything else needs two.
  function automatic logic [CNT_W-1:0] op_latency(input logic [SEL_W-1:0] sel);
    case (sel)
      OP_FWD, OP_AND, OP_OR: op_latency = CNT_W'(LAT_FAST);
      default:               op_latency = CNT_W'(LAT_SLOW);
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on a tie the
// requester named by ptr wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant_c = ptr ? 2'b10 : 2'b01;
      else                grant_c = valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, fixed-latency
// wait per opcode, then an ID-tagged response held until consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*SEL_W-1:0]    req_select,
  input  logic [2*DATA_W-1:0]   req_data1,
  input  logic [2*DATA_W-1:0]   req_data2,
  output logic [DATA_W-1:0]     alu_data1,
  output logic [DATA_W-1:0]     alu_data2,
  output logic [SEL_W-1:0]      alu_select,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_zero
);

  state_t           state, state_nxt;
  logic             ptr;
  logic [CNT_W-1:0] cnt;
  logic             id_q;
  alu_req_t         op_q;
  alu_req_t         win_req;
  logic [1:0]       grant;
  logic             win_id;
  logic             accept, capture, release_rsp;

  // Grant is suppressed outside IDLE and while reset is held.
  rr_arb2 u_arb (
    .valid   (req_valid),
    .ptr     (ptr),
    .en      ((state == IDLE) && !rst),
    .grant_c (grant)
  );

  assign req_ready = grant;
  assign win_id    = grant[1];

  always_comb begin
    win_req.sel   = win_id ? req_select[2*SEL_W-1:SEL_W]  : req_select[SEL_W-1:0];
    win_req.data1 = win_id ? req_data1[2*DATA_W-1:DATA_W] : req_data1[DATA_W-1:0];
    win_req.data2 = win_id ? req_data2[2*DATA_W-1:DATA_W] : req_data2[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: if (|(req_valid & grant)) begin
        accept    = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (cnt == CNT_W'(1)) begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: if (rsp_ready) begin
        release_rsp = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      cnt        <= '0;
      id_q       <= 1'b0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= win_req;
        id_q <= win_id;
        cnt  <= op_latency(win_req.sel);
        ptr  <= ~win_id;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_q;
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
      end else if (release_rsp) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_data1  = op_q.data1;
  assign alu_data2  = op_q.data2;
  assign alu_select = op_q.sel;

endmodule
